// File: rtl/gpio_pkg.sv
// Shared encodings for the GPIO input conditioner: interrupt sense modes, warm-up states, ISC field layout.
// Pure definitions; no logic, no latency.
package gpio_pkg;

  typedef enum logic [1:0] {
    ISC_LOW  = 2'b00,
    ISC_ANY  = 2'b01,
    ISC_FALL = 2'b10,
    ISC_RISE = 2'b11
  } isc_mode_e;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } warm_state_e;

  localparam int NUM_INT  = 2;
  localparam int ISC_W    = 2;
  localparam int ISC0_LSB = 0;
  localparam int ISC1_LSB = 2;

  function automatic logic edge_hit(input isc_mode_e mode, input logic rise, input logic fall);
    logic hit;
    case (mode)
      ISC_ANY:  hit = rise | fall;
      ISC_FALL: hit = fall;
      ISC_RISE: hit = rise;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic STAGES-deep flop chain for bringing asynchronous levels into the clk domain.
// Latency STAGES clocks, no backpressure; synchronous active-high clear empties every stage.
module sync_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_input_sync.sv
// Port A/B pad synchronizer plus INT0/INT1 edge/level detection with latched flags and masked requests.
// Pin-to-sync latency SYNC_STAGES clocks, flag +1, request +1; no backpressure.
module gpio_input_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int INT0_BIT    = 2,
  parameter int INT1_BIT    = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] PINA_pin,
  input  logic [WIDTH-1:0] PINB_pin,
  output logic [WIDTH-1:0] PINA_sync,
  output logic [WIDTH-1:0] PINB_sync,
  input  logic             isc_write_enable,
  input  logic [3:0]       isc_input_data,
  output logic [3:0]       isc_output,
  input  logic [1:0]       int_enable,
  input  logic [1:0]       intf_clear,
  output logic [1:0]       intf_output,
  output logic [1:0]       irq_request
);

  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W       = $clog2(WARM_CYCLES + 1);

  logic [WIDTH-1:0]   pina_sync;
  logic [WIDTH-1:0]   pinb_sync;

  logic [3:0]         isc_q, isc_d;
  logic [NUM_INT-1:0] prev_q;
  logic [NUM_INT-1:0] intf_q, intf_d;
  logic [NUM_INT-1:0] irq_q, irq_d;
  logic [NUM_INT-1:0] isc_chg, isc_chg_q;
  logic [NUM_INT-1:0] lvl, rise, fall, set;

  warm_state_e        state_q;
  logic [CNT_W-1:0]   warm_cnt_q;

  sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_a (
    .clk_i  (clk),
    .clr_i  (clr),
    .din_i  (PINA_pin),
    .dout_o (pina_sync)
  );

  sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_b (
    .clk_i  (clk),
    .clr_i  (clr),
    .din_i  (PINB_pin),
    .dout_o (pinb_sync)
  );

  // Edge detection stays off until the reset zeros have flushed through the synchronizer and prev.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= WARMUP;
      warm_cnt_q <= '0;
    end else if (state_q == WARMUP) begin
      if (warm_cnt_q == CNT_W'(WARM_CYCLES - 1)) state_q <= RUN;
      warm_cnt_q <= warm_cnt_q + CNT_W'(1);
    end
  end

  assign isc_d = isc_write_enable ? isc_input_data : isc_q;

  for (genvar n = 0; n < NUM_INT; n++) begin : g_int
    localparam int BIT = (n == 0) ? INT0_BIT : INT1_BIT;
    localparam int LSB = (n == 0) ? ISC0_LSB : ISC1_LSB;

    isc_mode_e mode;

    assign mode    = isc_mode_e'(isc_q[LSB +: ISC_W]);
    assign lvl[n]  = pinb_sync[BIT];
    assign rise[n] = lvl[n] & ~prev_q[n];
    assign fall[n] = ~lvl[n] & prev_q[n];

    // A mode switch can make a stale level look like an edge; mute this interrupt for two cycles.
    assign isc_chg[n] = isc_write_enable &
                        (isc_input_data[LSB +: ISC_W] != isc_q[LSB +: ISC_W]);

    assign set[n] = (state_q == RUN) & ~isc_chg[n] & ~isc_chg_q[n] &
                    edge_hit(mode, rise[n], fall[n]);

    assign intf_d[n] = set[n] | (intf_q[n] & ~intf_clear[n]);
    assign irq_d[n]  = int_enable[n] & ((mode == ISC_LOW) ? ~lvl[n] : intf_q[n]);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      isc_q     <= '0;
      prev_q    <= '0;
      intf_q    <= '0;
      irq_q     <= '0;
      isc_chg_q <= '0;
    end else begin
      isc_q     <= isc_d;
      prev_q    <= lvl;
      intf_q    <= intf_d;
      irq_q     <= irq_d;
      isc_chg_q <= isc_chg;
    end
  end

  assign PINA_sync   = pina_sync;
  assign PINB_sync   = pinb_sync;
  assign isc_output  = isc_q;
  assign intf_output = intf_q;
  assign irq_request = irq_q;

endmodule

// File: tb/tb_gpio_input_sync.sv
// Directed bench for gpio_input_sync: per-cycle vector table plus hand sequences for warm-up,
// ISC-switch muting and mid-operation reset. Inputs change on negedge, outputs sampled 1ns after posedge.
module tb_gpio_input_sync;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] PINA_pin, PINB_pin;
  logic [7:0] PINA_sync, PINB_sync;
  logic       isc_write_enable;
  logic [3:0] isc_input_data;
  logic [3:0] isc_output;
  logic [1:0] int_enable, intf_clear, intf_output, irq_request;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpio_input_sync #(.WIDTH(8), .SYNC_STAGES(2), .INT0_BIT(2), .INT1_BIT(3)) dut (
    .clk              (clk),
    .clr              (clr),
    .PINA_pin         (PINA_pin),
    .PINB_pin         (PINB_pin),
    .PINA_sync        (PINA_sync),
    .PINB_sync        (PINB_sync),
    .isc_write_enable (isc_write_enable),
    .isc_input_data   (isc_input_data),
    .isc_output       (isc_output),
    .int_enable       (int_enable),
    .intf_clear       (intf_clear),
    .intf_output      (intf_output),
    .irq_request      (irq_request)
  );

  typedef struct {
    logic       clr;
    logic [7:0] pa, pb;
    logic       we;
    logic [3:0] isc_d;
    logic [1:0] en, clrf;
    logic [7:0] e_pa, e_pb;
    logic [3:0] e_isc;
    logic [1:0] e_intf, e_irq;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  function automatic vec_t mk(input logic c, input logic [7:0] pa, input logic [7:0] pb,
                              input logic we, input logic [3:0] isc_d, input logic [1:0] en,
                              input logic [1:0] clrf, input logic [7:0] e_pa, input logic [7:0] e_pb,
                              input logic [3:0] e_isc, input logic [1:0] e_intf, input logic [1:0] e_irq);
    vec_t v;
    v.clr = c; v.pa = pa; v.pb = pb; v.we = we; v.isc_d = isc_d; v.en = en; v.clrf = clrf;
    v.e_pa = e_pa; v.e_pb = e_pb; v.e_isc = e_isc; v.e_intf = e_intf; v.e_irq = e_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [7:0] pa, input logic [7:0] pb, input logic we,
                       input logic [3:0] isc_d, input logic [1:0] en, input logic [1:0] clrf);
    @(negedge clk);
    clr = c; PINA_pin = pa; PINB_pin = pb; isc_write_enable = we;
    isc_input_data = isc_d; int_enable = en; intf_clear = clrf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; PINA_pin = '0; PINB_pin = '0; isc_write_enable = 1'b0;
    isc_input_data = '0; int_enable = '0; intf_clear = '0;

    //           clr pa     pb     we isc   en     clrf  | pa_s   pb_s   isc   intf   irq
    vt[0]  = mk(1, 8'h00, 8'h00, 0, 4'h0, 2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 2'b00, 2'b00);
    vt[1]  = mk(0, 8'hA5, 8'h00, 0, 4'h0, 2'b00, 2'b00, 8'h00, 8'h00, 4'h0, 2'b00, 2'b00);
    vt[2]  = mk(0, 8'hA5, 8'h00, 0, 4'h0, 2'b00, 2'b00, 8'hA5, 8'h00, 4'h0, 2'b00, 2'b00);
    vt[3]  = mk(0, 8'hA5, 8'h00, 1, 4'h3, 2'b00, 2'b00, 8'hA5, 8'h00, 4'h3, 2'b00, 2'b00);
    vt[4]  = mk(0, 8'hA5, 8'h04, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h00, 4'h3, 2'b00, 2'b00);
    vt[5]  = mk(0, 8'hA5, 8'h04, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h04, 4'h3, 2'b00, 2'b00);
    vt[6]  = mk(0, 8'hA5, 8'h04, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h04, 4'h3, 2'b01, 2'b00);
    vt[7]  = mk(0, 8'hA5, 8'h04, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h04, 4'h3, 2'b01, 2'b01);
    vt[8]  = mk(0, 8'hA5, 8'h04, 0, 4'h0, 2'b01, 2'b01, 8'hA5, 8'h04, 4'h3, 2'b00, 2'b01);
    vt[9]  = mk(0, 8'hA5, 8'h04, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h04, 4'h3, 2'b00, 2'b00);
    vt[10] = mk(0, 8'hA5, 8'h04, 1, 4'h4, 2'b00, 2'b00, 8'hA5, 8'h04, 4'h4, 2'b00, 2'b00);
    vt[11] = mk(0, 8'hA5, 8'h0C, 0, 4'h0, 2'b00, 2'b00, 8'hA5, 8'h04, 4'h4, 2'b00, 2'b00);
    vt[12] = mk(0, 8'hA5, 8'h0C, 0, 4'h0, 2'b00, 2'b00, 8'hA5, 8'h0C, 4'h4, 2'b00, 2'b00);
    vt[13] = mk(0, 8'hA5, 8'h0C, 0, 4'h0, 2'b00, 2'b10, 8'hA5, 8'h0C, 4'h4, 2'b10, 2'b00);
    vt[14] = mk(0, 8'hA5, 8'h0C, 0, 4'h0, 2'b00, 2'b00, 8'hA5, 8'h0C, 4'h4, 2'b10, 2'b00);
    vt[15] = mk(0, 8'hA5, 8'h0C, 0, 4'h0, 2'b00, 2'b10, 8'hA5, 8'h0C, 4'h4, 2'b00, 2'b00);
    vt[16] = mk(0, 8'hA5, 8'h0C, 1, 4'h0, 2'b00, 2'b00, 8'hA5, 8'h0C, 4'h0, 2'b00, 2'b00);
    vt[17] = mk(0, 8'hA5, 8'h08, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h0C, 4'h0, 2'b00, 2'b00);
    vt[18] = mk(0, 8'hA5, 8'h08, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h08, 4'h0, 2'b00, 2'b00);
    vt[19] = mk(0, 8'hA5, 8'h08, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h08, 4'h0, 2'b00, 2'b01);
    vt[20] = mk(0, 8'hA5, 8'h08, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h08, 4'h0, 2'b00, 2'b01);
    vt[21] = mk(0, 8'hA5, 8'h0C, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h08, 4'h0, 2'b00, 2'b01);
    vt[22] = mk(0, 8'hA5, 8'h0C, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h0C, 4'h0, 2'b00, 2'b01);
    vt[23] = mk(0, 8'hA5, 8'h0C, 0, 4'h0, 2'b01, 2'b00, 8'hA5, 8'h0C, 4'h0, 2'b00, 2'b00);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].clr, vt[i].pa, vt[i].pb, vt[i].we, vt[i].isc_d, vt[i].en, vt[i].clrf);
      tick();
      check($sformatf("vec%0d", i),
            32'({PINA_sync, PINB_sync, isc_output, intf_output, irq_request}),
            32'({vt[i].e_pa, vt[i].e_pb, vt[i].e_isc, vt[i].e_intf, vt[i].e_irq}));
    end

    // Warm-up: pad held high through reset, rising sense armed right after reset.
    drive(1, 8'h00, 8'hFF, 0, 4'h0, 2'b00, 2'b00); tick();
    check("rst_pa",   32'(PINA_sync),   32'h00);
    check("rst_pb",   32'(PINB_sync),   32'h00);
    check("rst_isc",  32'(isc_output),  32'h0);
    check("rst_intf", 32'(intf_output), 32'h0);
    check("rst_irq",  32'(irq_request), 32'h0);
    drive(0, 8'h00, 8'hFF, 1, 4'hF, 2'b00, 2'b00); tick();
    check("warm_pb_s1", 32'(PINB_sync),  32'h00);
    check("warm_isc",   32'(isc_output), 32'hF);
    drive(0, 8'h00, 8'hFF, 0, 4'h0, 2'b00, 2'b00); tick();
    check("warm_pb_s2", 32'(PINB_sync), 32'hFF);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("warm_intf%0d", k), 32'(intf_output), 32'h0);
    end

    // ISC0 FALL->ANY written in the very cycle a fall reaches lvl: the fall must be ignored.
    drive(0, 8'h00, 8'hFF, 1, 4'hE, 2'b00, 2'b00); tick();
    check("sw_isc_e", 32'(isc_output), 32'hE);
    drive(0, 8'h00, 8'hFF, 0, 4'h0, 2'b00, 2'b00); tick();
    drive(0, 8'h00, 8'hFB, 0, 4'h0, 2'b00, 2'b00); tick();
    tick();
    check("sw_pb_fb", 32'(PINB_sync), 32'hFB);
    drive(0, 8'h00, 8'hFB, 1, 4'hD, 2'b00, 2'b00); tick();
    check("sw_mute0", 32'(intf_output), 32'h0);
    check("sw_isc_d", 32'(isc_output),  32'hD);
    drive(0, 8'h00, 8'hFB, 0, 4'h0, 2'b00, 2'b00); tick();
    check("sw_mute1", 32'(intf_output), 32'h0);
    drive(0, 8'h00, 8'hFF, 0, 4'h0, 2'b00, 2'b00); tick();
    tick();
    check("sw_any_pre", 32'(intf_output), 32'h0);
    tick();
    check("sw_any_set", 32'(intf_output), 32'h1);

    // Mid-operation reset with a PB2 fall still inside the synchronizer.
    drive(0, 8'h5A, 8'hFF, 0, 4'h0, 2'b11, 2'b01); tick();
    check("mid_clear", 32'(intf_output), 32'h0);
    drive(0, 8'h5A, 8'hFB, 0, 4'h0, 2'b11, 2'b00); tick();
    check("mid_pa", 32'(PINA_sync), 32'h5A);
    drive(1, 8'h5A, 8'hFB, 0, 4'h0, 2'b00, 2'b00); tick();
    check("mid_rst_all",
          32'({PINA_sync, PINB_sync, isc_output, intf_output, irq_request}), 32'h0);
    drive(0, 8'h5A, 8'hFB, 1, 4'hF, 2'b00, 2'b00); tick();
    drive(0, 8'h5A, 8'hFB, 0, 4'h0, 2'b00, 2'b00);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("mid_intf%0d", k), 32'(intf_output), 32'h0);
    end
    check("mid_pb_end", 32'(PINB_sync),   32'hFB);
    check("mid_irq",    32'(irq_request), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
